digit_projection: RTL and testbench
===================================

Name: digit_projection

Overview:
- Upstream neighbour of the digit recognition stage. Builds row and column projections of the binarised (monochrome) image.
- Extracts the digit bounding borders into two small border RAMs. Reports digit row/column counts, the frame counter and the projection-done flag to the recogniser.
- Sits between the binarisation stage (monoc, xpos, ypos, frame_de) and the recogniser's border-RAM read ports.

Parameters:
- H_PIXEL, 1024: pixels per line (ypos range 0..H_PIXEL-1).
- V_PIXEL, 768: lines per frame (xpos range 0..V_PIXEL-1).
- MAX_SEG, 15: max row or column segments stored; counts saturate here.
- MIN_SEG, 4: minimum segment length in pixels/lines, used only with the optional filter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_vsync  in  1  one-cycle pulse at frame start.
- frame_de  in  1  active-pixel qualifier.
- monoc  in  1  pixel value; 0 = foreground (digit ink), 1 = background.
- xpos  in  11  current line index.
- ypos  in  11  current pixel index within line.
- restart  in  1  one-cycle pulse; discard results and re-project.
- row_border_addr  in  11  read address; even = top line, odd = bottom line of row segment addr>>1.
- row_border_data  out  11  registered read data, 1-cycle latency.
- col_border_addr  in  11  read address; even = left pixel, odd = right pixel of column segment addr>>1.
- col_border_data  out  11  registered read data, 1-cycle latency.
- frame_cnt  out  2  frames since start/restart; 0→1→2, holds at 2.
- project_done_flag  out  1  borders and counts valid.
- num_row  out  4  number of row segments found.
- num_col  out  4  number of column segments found.

Behaviour:
- Reset: all outputs 0; state IDLE; column-OR memory and border RAMs cleared (clear sweep of H_PIXEL cycles; frame_vsync ignored until it completes).
- frame_cnt increments on each frame_vsync while <2. restart sets it to 0, clears the done flag and counts, and re-enters IDLE with a clear sweep.
- State machine:
  - IDLE → COLLECT on frame_vsync when frame_cnt becomes 1. Frame 0 is discarded as partial.
  - COLLECT: per active pixel with monoc==0, set col_mem[ypos] and line_hit.
  - At ypos==H_PIXEL-1 with frame_de, evaluate line_hit:
    - 0→1 edge: open row segment, write top=xpos to addr 2k.
    - 1→0 edge: write bottom=xpos-1 to addr 2k+1, k+1.
    - line_hit clears every line.
  - After line V_PIXEL-1 completes → CLOSE.
  - CLOSE (1 cycle): an open row segment gets bottom=V_PIXEL-1. → SCAN.
  - SCAN: read col_mem[i], i=0..H_PIXEL-1, one per cycle. Apply the same open/close rule to produce left/right column borders. A column open at H_PIXEL-1 closes at H_PIXEL-1. → DONE.
  - DONE: project_done_flag=1, num_row/num_col valid and stable. Held until restart or rst. frame_vsync events only advance frame_cnt.
- Latency: project_done_flag rises exactly H_PIXEL+2 cycles after the last pixel of frame 1 (CLOSE + SCAN + flag register).
- frame_vsync arriving during SCAN does not abort the scan; frame_cnt still advances to 2.
- Segment overflow: after MAX_SEG segments, further segments are ignored. Count stays MAX_SEG; RAM entries beyond are untouched.
- Border RAM reads are valid at any time; contents are only meaningful while project_done_flag=1. Read addresses ≥2*MAX_SEG return 0.
- Empty frame: num_row=num_col=0, flag still asserted.
- Simultaneous restart and frame_vsync: restart wins; frame_cnt=0.

Optional Feature:
- PROJ_NOISE_FILTER_EN
  - Defined: a segment shorter than MIN_SEG (bottom-top+1 or right-left+1 < MIN_SEG) is discarded on close. Its count is not incremented and its RAM slot is reused by the next segment.
  - Undefined: every segment of length ≥1 is kept.

Test Plan:
- Single block digit, ink at lines 100..199, pixels 300..349, frame 1 → row addr0=100, addr1=199; col addr0=300, addr1=349; num_row=1, num_col=1; flag high H_PIXEL+2 cycles after frame end.
- Seven digits in one row, columns 100+120k..159+120k (k=0..6) → num_col=7, col border pairs match, num_row=1.
- Ink touching last line and last pixel (lines 700..767, pixels 1000..1023) → bottom=767, right=1023.
- 20 narrow separated columns → num_col=15; col addr 28/29 hold the 15th segment; addr 30 reads 0.
- With PROJ_NOISE_FILTER_EN, 2-pixel speck at 50..51 plus digit 300..349 → num_col=1, addr0=300. Without the macro → num_col=2.
- restart asserted mid-SCAN → flag stays 0, frame_cnt=0; next two frames produce correct borders from fresh data.

Source files
------------

// File: rtl/digit_projection_if.sv
// Pixel stream, border-RAM read ports and status lines between the binarisation
// stage, digit_projection and the recogniser.
interface digit_projection_if;
    logic        frame_vsync;
    logic        frame_de;
    logic        monoc;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        restart;
    logic [10:0] row_border_addr;
    logic [10:0] row_border_data;
    logic [10:0] col_border_addr;
    logic [10:0] col_border_data;
    logic [1:0]  frame_cnt;
    logic        project_done_flag;
    logic [3:0]  num_row;
    logic [3:0]  num_col;

    modport master (
        output frame_vsync, frame_de, monoc, xpos, ypos, restart,
        output row_border_addr, col_border_addr,
        input  row_border_data, col_border_data, frame_cnt,
        input  project_done_flag, num_row, num_col
    );

    modport slave (
        input  frame_vsync, frame_de, monoc, xpos, ypos, restart,
        input  row_border_addr, col_border_addr,
        output row_border_data, col_border_data, frame_cnt,
        output project_done_flag, num_row, num_col
    );
endinterface

// File: rtl/digit_projection.sv
// Row/column projection of the binarised image and digit border extraction.
// Optional short-segment rejection is enabled with `define PROJ_NOISE_FILTER_EN.
module digit_projection #(
    parameter int unsigned H_PIXEL = 1024,
    parameter int unsigned V_PIXEL = 768,
    parameter int unsigned MAX_SEG = 15,
    parameter int unsigned MIN_SEG = 4
) (
    input logic              clk,
    input logic              rst,
    digit_projection_if.slave bus
);

    localparam int unsigned CW    = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;
    localparam int unsigned RAM_N = 2 * MAX_SEG;
    localparam int unsigned AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;
`ifdef PROJ_NOISE_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam int unsigned MIN_LEN = FILTER_EN ? MIN_SEG : 1;

    localparam logic [10:0]   LAST_PIX  = 11'(H_PIXEL - 1);
    localparam logic [10:0]   LAST_LINE = 11'(V_PIXEL - 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(H_PIXEL - 1);
    localparam logic [3:0]    SEG_MAX   = 4'(MAX_SEG);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_COLLECT,
        S_CLOSE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [H_PIXEL-1:0] col_mem_q, col_mem_d;
    logic          line_hit_q, line_hit_d;
    logic          open_q, open_d;
    logic [10:0]   seg_start_q, seg_start_d;
    logic [3:0]    row_cnt_q, row_cnt_d;
    logic [3:0]    col_cnt_q, col_cnt_d;
    logic [10:0]   row_ram_q [RAM_N];
    logic [10:0]   row_ram_d [RAM_N];
    logic [10:0]   col_ram_q [RAM_N];
    logic [10:0]   col_ram_d [RAM_N];
    logic [1:0]    frame_cnt_q, frame_cnt_d;
    logic          flag_q, flag_d;
    logic [10:0]   row_rd_q, row_rd_d;
    logic [10:0]   col_rd_q, col_rd_d;

    logic          pix_hit;
    logic [10:0]   cur_pos;
    logic [10:0]   seg_end;
    logic [10:0]   seg_len;
    logic [AW-1:0] row_ev, row_od, col_ev, col_od;

    function automatic logic keep_seg(input logic [10:0] len);
        return len >= 11'(MIN_LEN);
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        col_mem_d   = col_mem_q;
        line_hit_d  = line_hit_q;
        open_d      = open_q;
        seg_start_d = seg_start_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        row_ram_d   = row_ram_q;
        col_ram_d   = col_ram_q;
        frame_cnt_d = frame_cnt_q;
        flag_d      = (state_q == S_DONE);
        pix_hit     = 1'b0;
        cur_pos     = 11'(idx_q);
        seg_end     = '0;
        seg_len     = '0;
        row_ev      = AW'({row_cnt_q, 1'b0});
        row_od      = AW'({row_cnt_q, 1'b1});
        col_ev      = AW'({col_cnt_q, 1'b0});
        col_od      = AW'({col_cnt_q, 1'b1});

        case (state_q)
            S_CLEAR: begin
                col_mem_d[idx_q] = 1'b0;
                row_ram_d = '{default: '0};
                col_ram_d = '{default: '0};
                idx_d = idx_q + CW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.frame_vsync) begin
                    state_d    = S_COLLECT;
                    line_hit_d = 1'b0;
                    open_d     = 1'b0;
                end
            end
            S_COLLECT: begin
                if (bus.frame_de && (bus.ypos <= LAST_PIX)) begin
                    pix_hit = line_hit_q | ~bus.monoc;
                    if (!bus.monoc) col_mem_d[bus.ypos[CW-1:0]] = 1'b1;
                    line_hit_d = pix_hit;
                    // Row decision is taken on the last pixel, including that pixel's ink.
                    if (bus.ypos == LAST_PIX) begin
                        line_hit_d = 1'b0;
                        if (!open_q && pix_hit && (row_cnt_q < SEG_MAX)) begin
                            row_ram_d[row_ev] = bus.xpos;
                            seg_start_d       = bus.xpos;
                            open_d            = 1'b1;
                        end else if (open_q && !pix_hit) begin
                            seg_end = bus.xpos - 11'd1;
                            seg_len = bus.xpos - seg_start_q;
                            open_d  = 1'b0;
                            if (keep_seg(seg_len)) begin
                                row_ram_d[row_od] = seg_end;
                                row_cnt_d         = row_cnt_q + 4'd1;
                            end
                        end
                        if (bus.xpos == LAST_LINE) state_d = S_CLOSE;
                    end
                end
            end
            S_CLOSE: begin
                if (open_q) begin
                    seg_len = LAST_LINE - seg_start_q + 11'd1;
                    if (keep_seg(seg_len)) begin
                        row_ram_d[row_od] = LAST_LINE;
                        row_cnt_d         = row_cnt_q + 4'd1;
                    end
                end
                open_d  = 1'b0;
                idx_d   = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                pix_hit = col_mem_q[idx_q];
                // A column starting on the last pixel opens and closes in the same cycle.
                if (!open_q && pix_hit && (col_cnt_q < SEG_MAX)) begin
                    col_ram_d[col_ev] = cur_pos;
                    seg_start_d       = cur_pos;
                    open_d            = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        open_d = 1'b0;
                        if (keep_seg(11'd1)) begin
                            col_ram_d[col_od] = cur_pos;
                            col_cnt_d         = col_cnt_q + 4'd1;
                        end
                    end
                end else if (open_q && (!pix_hit || (idx_q == LAST_IDX))) begin
                    seg_end = pix_hit ? cur_pos : (cur_pos - 11'd1);
                    seg_len = seg_end - seg_start_q + 11'd1;
                    open_d  = 1'b0;
                    if (keep_seg(seg_len)) begin
                        col_ram_d[col_od] = seg_end;
                        col_cnt_d         = col_cnt_q + 4'd1;
                    end
                end
                idx_d = idx_q + CW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
            end
            default: state_d = S_CLEAR;
        endcase

        if ((state_q != S_CLEAR) && bus.frame_vsync && (frame_cnt_q != 2'd2))
            frame_cnt_d = frame_cnt_q + 2'd1;

        if (bus.restart) begin
            state_d     = S_CLEAR;
            idx_d       = '0;
            frame_cnt_d = '0;
            flag_d      = 1'b0;
            row_cnt_d   = '0;
            col_cnt_d   = '0;
            open_d      = 1'b0;
            line_hit_d  = 1'b0;
        end
    end

    always_comb begin
        row_rd_d = '0;
        col_rd_d = '0;
        if (bus.row_border_addr < 11'(RAM_N)) row_rd_d = row_ram_q[bus.row_border_addr[AW-1:0]];
        if (bus.col_border_addr < 11'(RAM_N)) col_rd_d = col_ram_q[bus.col_border_addr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            idx_q       <= '0;
            line_hit_q  <= 1'b0;
            open_q      <= 1'b0;
            seg_start_q <= '0;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            frame_cnt_q <= '0;
            flag_q      <= 1'b0;
            row_rd_q    <= '0;
            col_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            line_hit_q  <= line_hit_d;
            open_q      <= open_d;
            seg_start_q <= seg_start_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            flag_q      <= flag_d;
            row_rd_q    <= row_rd_d;
            col_rd_q    <= col_rd_d;
        end
    end

    // Storage arrays are wiped by the clear sweep that follows reset, not by rst itself.
    always_ff @(posedge clk) begin
        col_mem_q <= col_mem_d;
        row_ram_q <= row_ram_d;
        col_ram_q <= col_ram_d;
    end

    assign bus.row_border_data   = row_rd_q;
    assign bus.col_border_data   = col_rd_q;
    assign bus.frame_cnt         = frame_cnt_q;
    assign bus.project_done_flag = flag_q;
    assign bus.num_row           = row_cnt_q;
    assign bus.num_col           = col_cnt_q;

endmodule

// File: tb/tb_digit_projection.sv
// Self-checking bench for digit_projection on a reduced 112x32 frame.
module tb_digit_projection;

    localparam int H    = 112;
    localparam int V    = 32;
    localparam int MAXS = 15;
    localparam int MINS = 4;
`ifdef PROJ_NOISE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        int r_lo; int r_hi;
        int c_lo; int c_w; int c_step; int c_n;
        int sp_lo; int sp_hi;
        int nrow; int ncol;
        int r0; int r1; int c0; int c1;
    } case_t;

    logic clk;
    logic rst;
    digit_projection_if bus_if ();

    digit_projection #(
        .H_PIXEL(H),
        .V_PIXEL(V),
        .MAX_SEG(MAXS),
        .MIN_SEG(MINS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int row_q[$];
    int col_q[$];
    int exp_row[34];
    int exp_col[34];
    case_t tab[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit ink(input case_t tc, input int x, input int y);
        if (tc.r_lo < 0 || x < tc.r_lo || x > tc.r_hi) return 1'b0;
        if (tc.sp_lo >= 0 && y >= tc.sp_lo && y <= tc.sp_hi) return 1'b1;
        for (int k = 0; k < tc.c_n; k++)
            if (y >= tc.c_lo + k * tc.c_step && y < tc.c_lo + k * tc.c_step + tc.c_w) return 1'b1;
        return 1'b0;
    endfunction

    task automatic extract(input bit b[H], input int len, output int ram[34]);
        int cnt = 0;
        int s = -1;
        for (int i = 0; i < 34; i++) ram[i] = 0;
        for (int i = 0; i <= len; i++) begin
            bit v;
            v = (i < len) ? b[i] : 1'b0;
            if (v && s < 0) s = i;
            else if (!v && s >= 0) begin
                if ((!FILT || (i - s) >= MINS) && cnt < MAXS) begin
                    ram[2 * cnt]     = s;
                    ram[2 * cnt + 1] = i - 1;
                    cnt++;
                end
                s = -1;
            end
        end
    endtask

    task automatic build_model(input case_t tc);
        bit rp[H];
        bit cp[H];
        for (int i = 0; i < H; i++) begin rp[i] = 1'b0; cp[i] = 1'b0; end
        for (int x = 0; x < V; x++)
            for (int y = 0; y < H; y++)
                if (ink(tc, x, y)) begin rp[x] = 1'b1; cp[y] = 1'b1; end
        extract(rp, V, exp_row);
        extract(cp, H, exp_col);
    endtask

    task automatic rd(input string tag, input int a, input int er, input int ec);
        bus_if.row_border_addr = 11'(a);
        bus_if.col_border_addr = 11'(a);
        row_q.push_back(er);
        col_q.push_back(ec);
        @(posedge clk); #1;
        chk($sformatf("%s_row_addr%0d", tag, a), int'(bus_if.row_border_data), row_q.pop_front());
        chk($sformatf("%s_col_addr%0d", tag, a), int'(bus_if.col_border_data), col_q.pop_front());
    endtask

    // Optional restart, clear sweep (with an ignored vsync), first vsync, then one full frame.
    task automatic start_frame(input case_t tc, input bit do_rs);
        int rose = 0;
        if (do_rs) begin
            bus_if.restart = 1'b1;
            @(posedge clk); #1;
            bus_if.restart = 1'b0;
        end
        for (int i = 0; i < H + 4; i++) begin
            bus_if.frame_vsync = (i == 3);
            @(posedge clk); #1;
            if (bus_if.project_done_flag) rose = 1;
        end
        bus_if.frame_vsync = 1'b0;
        chk("flag_low_during_clear", rose, 0);
        chk("frame_cnt_after_clear", int'(bus_if.frame_cnt), 0);
        chk("num_row_after_clear", int'(bus_if.num_row), 0);
        bus_if.frame_vsync = 1'b1;
        @(posedge clk); #1;
        bus_if.frame_vsync = 1'b0;
        chk("frame_cnt_first_vsync", int'(bus_if.frame_cnt), 1);
        for (int x = 0; x < V; x++)
            for (int y = 0; y < H; y++) begin
                bus_if.frame_de = 1'b1;
                bus_if.xpos     = 11'(x);
                bus_if.ypos     = 11'(y);
                bus_if.monoc    = ~ink(tc, x, y);
                @(posedge clk); #1;
            end
        bus_if.frame_de = 1'b0;
        bus_if.monoc    = 1'b1;
    endtask

    task automatic complete_frame(input string tag, input case_t tc);
        int n = 0;
        int got = 0;
        while (n < 4 * H && got == 0) begin
            bus_if.frame_vsync = (n == 5);
            @(posedge clk); #1;
            n++;
            if (bus_if.project_done_flag) got = 1;
        end
        bus_if.frame_vsync = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        if (got == 1) chk({tag, "_done_latency"}, n, H + 2);
        chk({tag, "_frame_cnt_after_scan_vsync"}, int'(bus_if.frame_cnt), 2);
        chk({tag, "_num_row"}, int'(bus_if.num_row), tc.nrow);
        chk({tag, "_num_col"}, int'(bus_if.num_col), tc.ncol);
        rd({tag, "_first"}, 0, tc.r0, tc.c0);
        rd({tag, "_first"}, 1, tc.r1, tc.c1);
        build_model(tc);
        for (int a = 0; a < 34; a++) rd({tag, "_model"}, a, exp_row[a], exp_col[a]);
        bus_if.frame_vsync = 1'b1;
        @(posedge clk); #1;
        bus_if.frame_vsync = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_frame_cnt_hold"}, int'(bus_if.frame_cnt), 2);
        chk({tag, "_flag_hold"}, int'(bus_if.project_done_flag), 1);
        chk({tag, "_num_col_hold"}, int'(bus_if.num_col), tc.ncol);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int low;
        tab[0] = '{10, 19, 20, 10, 0, 1, -1, -1, 1, 1, 10, 19, 20, 29};
        tab[1] = '{5, 9, 2, 4, 6, 7, -1, -1, 1, 7, 5, 9, 2, 5};
        tab[2] = '{28, 31, 100, 12, 0, 1, -1, -1, 1, 1, 28, 31, 100, 111};
        tab[3] = '{4, 9, 0, 4, 5, 20, -1, -1, 1, 15, 4, 9, 0, 3};
        tab[4] = '{10, 19, 20, 10, 0, 1, 5, 6, 1, FILT ? 1 : 2, 10, 19, FILT ? 20 : 5, FILT ? 29 : 6};
        tab[5] = '{-1, -1, 0, 0, 0, 0, -1, -1, 0, 0, 0, 0, 0, 0};
        tab[6] = '{3, 7, 60, 20, 0, 1, -1, -1, 1, 1, 3, 7, 60, 79};

        rst = 1'b1;
        bus_if.frame_vsync     = 1'b0;
        bus_if.frame_de        = 1'b0;
        bus_if.monoc           = 1'b1;
        bus_if.xpos            = '0;
        bus_if.ypos            = '0;
        bus_if.restart         = 1'b0;
        bus_if.row_border_addr = '0;
        bus_if.col_border_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_flag", int'(bus_if.project_done_flag), 0);
        chk("reset_frame_cnt", int'(bus_if.frame_cnt), 0);
        chk("reset_num_row", int'(bus_if.num_row), 0);
        chk("reset_num_col", int'(bus_if.num_col), 0);
        chk("reset_row_data", int'(bus_if.row_border_data), 0);
        chk("reset_col_data", int'(bus_if.col_border_data), 0);

        for (int t = 0; t < 6; t++) begin
            start_frame(tab[t], 1'b1);
            complete_frame($sformatf("case%0d", t), tab[t]);
        end

        // Restart together with vsync in the middle of the column scan.
        start_frame(tab[0], 1'b1);
        low = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_if.project_done_flag) low = 0;
        end
        bus_if.restart     = 1'b1;
        bus_if.frame_vsync = 1'b1;
        @(posedge clk); #1;
        bus_if.restart     = 1'b0;
        bus_if.frame_vsync = 1'b0;
        chk("midscan_flag_low", low, 1);
        chk("restart_vsync_frame_cnt", int'(bus_if.frame_cnt), 0);
        chk("restart_flag", int'(bus_if.project_done_flag), 0);
        chk("restart_num_row", int'(bus_if.num_row), 0);
        start_frame(tab[6], 1'b0);
        complete_frame("fresh", tab[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
